// File: rtl/pong_pkg.sv
// Shared types and defaults for the pong match sequencer.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    PAUSE     = 3'd3,
    POINT     = 3'd4,
    GAME_OVER = 3'd5
  } match_state_t;

  localparam int unsigned WIN_SCORE_DEF    = 7;
  localparam int unsigned SERVE_FRAMES_DEF = 60;

endpackage

// File: rtl/pong_match_ctrl_key_edge.sv
// Registered rising-edge detector for a raw key level.
module key_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic evt_o
);

  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
      evt_o  <= 1'b0;
    end else begin
      prev_q <= key_i;
      evt_o  <= key_i & ~prev_q;
    end
  end

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer: state machine, scores, serve/point timing and pause.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = WIN_SCORE_DEF,
  parameter int unsigned SERVE_FRAMES = SERVE_FRAMES_DEF,
  parameter int unsigned POINT_FRAMES = 30,
  parameter int unsigned SCORE_W      = 4,
  parameter int unsigned FRAME_CNT_W  = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               new_frame_i,
  input  logic               start_key_i,
  input  logic               pause_key_i,
  input  logic               miss_player_i,
  input  logic               miss_pc_i,
  output logic               run_o,
  output logic               serve_o,
  output logic               serve_dir_o,
  output logic [SCORE_W-1:0] score_player_o,
  output logic [SCORE_W-1:0] score_pc_o,
  output logic [2:0]         state_o,
  output logic               winner_o
);

  localparam logic [SCORE_W-1:0]     WIN_L   = SCORE_W'(WIN_SCORE);
  localparam logic [FRAME_CNT_W-1:0] SERVE_L = FRAME_CNT_W'(SERVE_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] POINT_L = FRAME_CNT_W'(POINT_FRAMES);

  match_state_t           state_q, state_d;
  logic [FRAME_CNT_W-1:0] cnt_q;
  logic [SCORE_W-1:0]     sp_q, spc_q;
  logic                   dir_q, run_q, serve_q;
  logic                   start_evt, pause_evt;
  logic                   load_serve, load_point, cnt_dec;
  logic                   clr_scores, inc_player, inc_pc;
  logic                   cnt_zero, win_reached;
  logic                   both_miss, pc_only, pl_only, pause_only;

  key_edge u_start_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .key_i  (start_key_i),
    .evt_o  (start_evt)
  );

  key_edge u_pause_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .key_i  (pause_key_i),
    .evt_o  (pause_evt)
  );

  assign cnt_zero    = (cnt_q == '0);
  assign win_reached = (sp_q == WIN_L) || (spc_q == WIN_L);
  assign both_miss   = miss_pc_i & miss_player_i;
  assign pc_only     = miss_pc_i & ~miss_player_i;
  assign pl_only     = miss_player_i & ~miss_pc_i;
  assign pause_only  = pause_evt & ~miss_pc_i & ~miss_player_i;

  always_comb begin
    state_d    = state_q;
    load_serve = 1'b0;
    load_point = 1'b0;
    cnt_dec    = 1'b0;
    clr_scores = 1'b0;
    inc_player = 1'b0;
    inc_pc     = 1'b0;
    case (state_q)
      IDLE: if (start_evt) begin
        clr_scores = 1'b1;
        load_serve = 1'b1;
        state_d    = SERVE;
      end
      SERVE: if (new_frame_i) begin
        if (cnt_zero) state_d = PLAY;
        else          cnt_dec = 1'b1;
      end
      PLAY: begin
        // a miss outranks a pause edge in the same cycle
        unique case (1'b1)
          both_miss: begin
            load_point = 1'b1;
            state_d    = POINT;
          end
          pc_only: begin
            inc_player = 1'b1;
            load_point = 1'b1;
            state_d    = POINT;
          end
          pl_only: begin
            inc_pc     = 1'b1;
            load_point = 1'b1;
            state_d    = POINT;
          end
          pause_only: state_d = PAUSE;
          default: ;
        endcase
      end
      PAUSE: begin
        if (start_evt)      state_d = IDLE;
        else if (pause_evt) state_d = PLAY;
      end
      POINT: if (new_frame_i) begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (win_reached) begin
          state_d = GAME_OVER;
        end else begin
          load_serve = 1'b1;
          state_d    = SERVE;
        end
      end
      GAME_OVER: if (start_evt) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
      serve_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= (state_d == PLAY);
      serve_q <= (state_q == SERVE) && (state_d == PLAY);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)         cnt_q <= '0;
    else if (load_serve) cnt_q <= SERVE_L;
    else if (load_point) cnt_q <= POINT_L;
    else if (cnt_dec)    cnt_q <= cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sp_q  <= '0;
      spc_q <= '0;
      dir_q <= 1'b1;
    end else if (clr_scores) begin
      sp_q  <= '0;
      spc_q <= '0;
    end else begin
      // the next serve goes toward whoever just lost the point
      if (inc_player) begin
        if (sp_q != WIN_L) sp_q <= sp_q + 1'b1;
        dir_q <= 1'b0;
      end
      if (inc_pc) begin
        if (spc_q != WIN_L) spc_q <= spc_q + 1'b1;
        dir_q <= 1'b1;
      end
    end
  end

  assign run_o          = run_q;
  assign serve_o        = serve_q;
  assign serve_dir_o    = dir_q;
  assign score_player_o = sp_q;
  assign score_pc_o     = spc_q;
  assign state_o        = state_q;
  assign winner_o       = (state_q == GAME_OVER) && (sp_q == WIN_L);

endmodule
